// File: rtl/fir_bridge_pkg.sv
// Shared constants for the Wishbone-to-stream FIR bridge:
// register offsets, STAT bit positions and the address decoder.
package fir_bridge_pkg;

  localparam logic [7:0] OFS_X    = 8'h80;
  localparam logic [7:0] OFS_Y    = 8'h84;
  localparam logic [7:0] OFS_STAT = 8'h88;
  localparam logic [7:0] OFS_LEN  = 8'h8C;
  localparam logic [7:0] OFS_LAT  = 8'h90;

  localparam int STAT_X_FULL  = 0;
  localparam int STAT_X_EMPTY = 1;
  localparam int STAT_Y_FULL  = 2;
  localparam int STAT_Y_EMPTY = 3;
  localparam int STAT_Y_LAST  = 4;
  localparam int STAT_XCNT    = 8;
  localparam int STAT_YCNT    = 16;

  typedef enum logic [2:0] {
    REG_X,
    REG_Y,
    REG_STAT,
    REG_LEN,
    REG_LAT,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode(
    input logic [7:0] a
  );
    reg_sel_e r;
    r = REG_NONE;
    unique case (1'b1)
      (a == OFS_X):    r = REG_X;
      (a == OFS_Y):    r = REG_Y;
      (a == OFS_STAT): r = REG_STAT;
      (a == OFS_LEN):  r = REG_LEN;
      (a == OFS_LAT):  r = REG_LAT;
      default:         r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_fir_stream_bridge_if.sv
// Bridge bus bundle: Wishbone slave port, ss_* X stream out, sm_* Y stream in.
// slave = bridge side, master = firmware/FIR side.
interface wb_fir_stream_bridge_if #(
  parameter int DW = 32
);
  logic          wbs_cyc_i;
  logic          wbs_stb_i;
  logic          wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_adr_i;
  logic [31:0]   wbs_dat_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          ss_tvalid;
  logic [DW-1:0] ss_tdata;
  logic          ss_tlast;
  logic          ss_tready;
  logic          sm_tvalid;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;
  logic          sm_tready;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output ss_tvalid, ss_tdata, ss_tlast,
    input  ss_tready,
    input  sm_tvalid, sm_tdata, sm_tlast,
    output sm_tready
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  ss_tvalid, ss_tdata, ss_tlast,
    output ss_tready,
    output sm_tvalid, sm_tdata, sm_tlast,
    input  sm_tready
  );
endinterface

// File: rtl/fir_bridge_fifo.sv
// Synchronous FIFO with flop storage; head word is always visible on dout.
// Ports: clk, rst (sync, high), push/din, pop/dout, full, empty, count.
module fir_bridge_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [7:0]       count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == 8'(DEPTH));
  assign empty   = (count == 8'd0);
  // a full FIFO refuses a push even when a pop frees a slot this cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 8'd1;
        2'b01:   count <= count - 8'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_fir_stream_bridge.sv
// Wishbone MMIO bridge: X writes -> FIFO -> ss_* stream; sm_* -> FIFO -> Y reads.
// Ports: wb_clk_i, wb_rst_i (sync, high), bus (wb_fir_stream_bridge_if.slave). Option: FIR_BRIDGE_LATENCY_EN.
module wb_fir_stream_bridge
  import fir_bridge_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input logic                   wb_clk_i,
  input logic                   wb_rst_i,
  wb_fir_stream_bridge_if.slave bus
);
  logic          x_push, x_pop, x_full, x_empty;
  logic [7:0]    x_cnt;
  logic [DW-1:0] x_dout;
  logic          y_push, y_pop, y_full, y_empty;
  logic [7:0]    y_cnt;
  logic [DW:0]   y_dout;

  logic [15:0]   len_q;
  logic [15:0]   smp_q;
  logic          y_last_q;
  logic          ack_q;
  logic [31:0]   dat_q;

  reg_sel_e      rsel;
  logic          req, stall, accept;
  logic          len_wr, stat_wr, tlast;
  logic [31:0]   stat, rd_data, lat_val;
  logic          unused_ok;

  assign unused_ok = ^{bus.wbs_adr_i[31:8], bus.wbs_sel_i[3:2]};

  // ack_q blocks a held strobe from being taken twice
  assign req    = bus.wbs_cyc_i && bus.wbs_stb_i && !ack_q;
  assign rsel   = decode(bus.wbs_adr_i[7:0]);
  assign stall  = (rsel == REG_X && bus.wbs_we_i && x_full)
               || (rsel == REG_Y && !bus.wbs_we_i && y_empty);
  assign accept = req && !stall && !wb_rst_i;

  assign x_push  = accept && bus.wbs_we_i && rsel == REG_X;
  assign y_pop   = accept && !bus.wbs_we_i && rsel == REG_Y;
  assign len_wr  = accept && bus.wbs_we_i && rsel == REG_LEN;
  assign stat_wr = accept && bus.wbs_we_i && rsel == REG_STAT;

  assign x_pop  = bus.ss_tvalid && bus.ss_tready;
  assign y_push = bus.sm_tvalid && bus.sm_tready;
  assign tlast  = (len_q != 16'd0) && (smp_q == len_q - 16'd1);

  assign bus.ss_tvalid = !x_empty && !wb_rst_i;
  assign bus.ss_tdata  = x_dout;
  assign bus.ss_tlast  = bus.ss_tvalid && tlast;
  assign bus.sm_tready = !y_full && !wb_rst_i;
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;

  fir_bridge_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_xfifo (
    .clk(wb_clk_i), .rst(wb_rst_i),
    .push(x_push), .din(DW'(bus.wbs_dat_i)),
    .pop(x_pop), .dout(x_dout),
    .full(x_full), .empty(x_empty), .count(x_cnt)
  );

  fir_bridge_fifo #(.WIDTH(DW + 1), .DEPTH(DEPTH)) u_yfifo (
    .clk(wb_clk_i), .rst(wb_rst_i),
    .push(y_push), .din({bus.sm_tlast, bus.sm_tdata}),
    .pop(y_pop), .dout(y_dout),
    .full(y_full), .empty(y_empty), .count(y_cnt)
  );

  always_comb begin
    stat = '0;
    stat[STAT_X_FULL]       = x_full;
    stat[STAT_X_EMPTY]      = x_empty;
    stat[STAT_Y_FULL]       = y_full;
    stat[STAT_Y_EMPTY]      = y_empty;
    stat[STAT_Y_LAST]       = y_last_q;
    stat[STAT_XCNT +: 8]    = x_cnt;
    stat[STAT_YCNT +: 8]    = y_cnt;
  end

  always_comb begin
    rd_data = '0;
    unique case (rsel)
      REG_Y:    rd_data = 32'(y_dout[DW-1:0]);
      REG_STAT: rd_data = stat;
      REG_LEN:  rd_data = {16'h0, len_q};
      REG_LAT:  rd_data = lat_val;
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      len_q    <= '0;
      smp_q    <= '0;
      y_last_q <= 1'b0;
    end else begin
      ack_q <= accept;
      dat_q <= accept ? rd_data : '0;
      if (len_wr) begin
        if (bus.wbs_sel_i[0]) len_q[7:0]  <= bus.wbs_dat_i[7:0];
        if (bus.wbs_sel_i[1]) len_q[15:8] <= bus.wbs_dat_i[15:8];
      end
      if (len_wr)     smp_q <= '0;
      else if (x_pop) smp_q <= tlast ? '0 : smp_q + 16'd1;
      if (stat_wr)                   y_last_q <= 1'b0;
      else if (y_pop && y_dout[DW])  y_last_q <= 1'b1;
    end
  end

`ifdef FIR_BRIDGE_LATENCY_EN
  logic [31:0] lat_q;
  logic        lat_run;
  logic        lat_arm;

  assign lat_val = lat_q;

  // arm on reset/LEN write, run from the next X push until the last Y pop
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || len_wr) begin
      lat_q   <= '0;
      lat_run <= 1'b0;
      lat_arm <= 1'b1;
    end else begin
      if (lat_arm && x_push) begin
        lat_run <= 1'b1;
        lat_arm <= 1'b0;
      end
      if (lat_run) begin
        if (lat_q != '1) lat_q <= lat_q + 32'd1;
        if (y_pop && y_dout[DW]) lat_run <= 1'b0;
      end
    end
  end
`else
  assign lat_val = '0;
`endif

endmodule

// File: tb/tb_wb_fir_stream_bridge.sv
// Scoreboard bench for wb_fir_stream_bridge: queued WB and ss expectations
// checked by a negedge monitor; directed vectors.
module tb_wb_fir_stream_bridge;
  import fir_bridge_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_fir_stream_bridge_if #(.DW(DW)) bus ();

  wb_fir_stream_bridge #(.DEPTH(DEPTH), .DW(DW)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus)
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] val;
    string       name;
  } wb_exp_t;

  wb_exp_t     wb_q[$];
  logic [DW:0] ss_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int last_k;
  int last_ack_cyc;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wb_exp_t e;
    logic [DW:0] s;
    if (bus.wbs_ack_o) begin
      if (wb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack=1 expected none");
      end else begin
        e = wb_q.pop_front();
        if (e.is_rd) chk(e.name, bus.wbs_dat_o, e.val);
      end
    end
    if (bus.ss_tvalid && bus.ss_tready) begin
      if (ss_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ss: got %0h expected none",
                 bus.ss_tdata);
      end else begin
        s = ss_q.pop_front();
        chk("ss_data", bus.ss_tdata, s[DW-1:0]);
        chk("ss_last", bus.ss_tlast, s[DW]);
      end
    end
  end

  task automatic wb_op(input bit we, input logic [7:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input logic [31:0] exp, input string nm,
                       input int maxw, input bit exp_now);
    int k;
    bit acked;
    wb_q.push_back('{!we, exp, nm});
    @(posedge clk);
    #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = {24'h3000_00, adr};
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    k = 0;
    acked = 1'b0;
    while (k < maxw) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        break;
      end
      k++;
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    last_k = k;
    last_ack_cyc = cyc_n;
    if (!acked) begin
      void'(wb_q.pop_back());
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no ack expected ack", nm);
    end else if (exp_now) begin
      chk({nm, "_lat"}, k, 0);
    end
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] dat,
                    input string nm);
    wb_op(1'b1, adr, dat, 4'hF, 32'h0, nm, 20, 1'b1);
  endtask

  task automatic rd(input logic [7:0] adr, input logic [31:0] exp,
                    input string nm);
    wb_op(1'b0, adr, 32'h0, 4'hF, exp, nm, 20, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    logic [31:0] lat_exp;
    bus.wbs_cyc_i = 0;
    bus.wbs_stb_i = 0;
    bus.wbs_we_i  = 0;
    bus.wbs_sel_i = 0;
    bus.wbs_adr_i = 0;
    bus.wbs_dat_i = 0;
    bus.ss_tready = 0;
    bus.sm_tvalid = 0;
    bus.sm_tdata  = 0;
    bus.sm_tlast  = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss_tvalid", bus.ss_tvalid, 0);
    chk("rst_sm_tready", bus.sm_tready, 0);
    chk("rst_ack", bus.wbs_ack_o, 0);
    chk("rst_dat", bus.wbs_dat_o, 0);
    rst = 1'b0;

    rd(OFS_STAT, 32'h0000_000A, "stat_reset");
    rd(8'h44, 32'h0, "unmapped_rd");
    wr(8'h44, 32'hDEAD_BEEF, "unmapped_wr");
    wr(OFS_LEN, 32'h0000_1234, "len_full");
    wb_op(1'b1, OFS_LEN, 32'h0000_FF56, 4'h1, 32'h0, "len_b0", 20, 1'b1);
    rd(OFS_LEN, 32'h0000_1256, "len_mask");
    rd(OFS_LAT, 32'h0, "lat_idle");

    // LEN=0: tlast never raised
    wr(OFS_LEN, 32'h0, "len0");
    bus.ss_tready = 1'b1;
    ss_q.push_back({1'b0, 32'h21});
    ss_q.push_back({1'b0, 32'h22});
    wr(OFS_X, 32'h21, "x_len0_a");
    wr(OFS_X, 32'h22, "x_len0_b");
    repeat (3) @(posedge clk);

    // block of 4
    wr(OFS_LEN, 32'h4, "len4");
    for (int i = 1; i <= 4; i++) begin
      ss_q.push_back({(i == 4), 32'(i)});
      wr(OFS_X, 32'(i), "x_blk4");
    end
    repeat (4) @(posedge clk);
    rd(OFS_STAT, 32'h0000_000A, "stat_drained");

    // X FIFO full, stalled write released by one ss_tready pulse
    #1;
    bus.ss_tready = 1'b0;
    for (int i = 0; i < 9; i++)
      ss_q.push_back({(i == 3 || i == 7), 32'(16 + i)});
    for (int i = 0; i < DEPTH; i++)
      wr(OFS_X, 32'(16 + i), "x_fill");
    rd(OFS_STAT, 32'h0000_0809, "stat_xfull");
    fork
      wb_op(1'b1, OFS_X, 32'(16 + DEPTH), 4'hF, 32'h0, "x_stall", 30, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1;
        bus.ss_tready = 1'b1;
        @(posedge clk);
        #1;
        bus.ss_tready = 1'b0;
      end
    join
    chk("x_stall_wait", last_k, 6);
    bus.ss_tready = 1'b1;
    repeat (12) @(posedge clk);
    rd(OFS_STAT, 32'h0000_000A, "stat_x_drained");

    // Y read on empty FIFO waits for the FIR
    fork
      wb_op(1'b0, OFS_Y, 32'h0, 4'hF, 32'h0000_0726, "y_wait", 30, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.sm_tvalid = 1'b1;
        bus.sm_tdata  = 32'h0000_0726;
        bus.sm_tlast  = 1'b1;
        @(posedge clk);
        #1;
        bus.sm_tvalid = 1'b0;
        bus.sm_tlast  = 1'b0;
      end
    join
    chk("y_stall_wait", last_k, 4);
    rd(OFS_STAT, 32'h0000_001A, "stat_ylast");
    wr(OFS_STAT, 32'h0, "stat_clr");
    rd(OFS_STAT, 32'h0000_000A, "stat_cleared");

    // Y FIFO full, then simultaneous pop and push
    bus.sm_tvalid = 1'b1;
    bus.sm_tdata  = 32'h55;
    repeat (12) @(posedge clk);
    #1;
    chk("sm_tready_full", bus.sm_tready, 0);
    rd(OFS_STAT, 32'h0008_0006, "stat_yfull");
    bus.sm_tvalid = 1'b0;
    rd(OFS_Y, 32'h55, "y_pop_first");
    fork
      rd(OFS_Y, 32'h55, "y_pop_push");
      begin
        @(posedge clk);
        #1;
        bus.sm_tvalid = 1'b1;
        bus.sm_tdata  = 32'h66;
        @(posedge clk);
        #1;
        bus.sm_tvalid = 1'b0;
      end
    join
    rd(OFS_STAT, 32'h0007_0002, "stat_ycount");
    for (int i = 0; i < DEPTH - 2; i++)
      rd(OFS_Y, 32'h55, "y_drain");
    rd(OFS_Y, 32'h66, "y_drain_last");
    rd(OFS_STAT, 32'h0000_000A, "stat_y_drained");

    // block of 11 and latency counter
    wr(OFS_LEN, 32'd11, "len11");
    for (int i = 0; i < 11; i++) begin
      ss_q.push_back({(i == 10), 32'(256 + i)});
      wr(OFS_X, 32'(256 + i), "x_blk11");
      if (i == 0) t0 = last_ack_cyc;
    end
    @(posedge clk);
    #1;
    bus.sm_tvalid = 1'b1;
    bus.sm_tdata  = 32'h900;
    bus.sm_tlast  = 1'b1;
    @(posedge clk);
    #1;
    bus.sm_tvalid = 1'b0;
    bus.sm_tlast  = 1'b0;
    rd(OFS_Y, 32'h900, "y_blk11_last");
    t1 = last_ack_cyc;
`ifdef FIR_BRIDGE_LATENCY_EN
    lat_exp = 32'(t1 - t0);
`else
    lat_exp = 32'h0;
`endif
    repeat (3) @(posedge clk);
    rd(OFS_LAT, lat_exp, "lat_block");

    // reset while an X write is stalled
    bus.ss_tready = 1'b0;
    wr(OFS_LEN, 32'h4, "len4_b");
    for (int i = 0; i < DEPTH; i++)
      wr(OFS_X, 32'(64 + i), "x_fill_b");
    @(posedge clk);
    #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = {24'h3000_00, OFS_X};
    bus.wbs_dat_i = 32'h77;
    bus.wbs_sel_i = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_no_ack", bus.wbs_ack_o, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ss_tvalid", bus.ss_tvalid, 0);
    chk("midrst_ack", bus.wbs_ack_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    rd(OFS_STAT, 32'h0000_000A, "stat_after_rst");
    chk("post_rst_ss_tvalid", bus.ss_tvalid, 0);

    repeat (5) @(posedge clk);
    if (wb_q.size() != 0 || ss_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: got wb=%0d ss=%0d expected 0",
               wb_q.size(), ss_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
